// File: rtl/pong_motion_gen.sv
// Pong motion generator: ball, paddle and score state advanced once per video frame.
// Each frame starts on the first clock that sees a falling edge of vs.
module pong_motion_gen #(
  parameter int W            = 10,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int PAD_MARGIN   = 16,
  parameter int BALL_STEP    = 2,
  parameter int PAD_STEP     = 1,
  parameter int SERVE_FRAMES = 60
) (
  input  logic         clk50M,
  input  logic         rst,
  input  logic         en,
  input  logic         vs,
  output logic [W-1:0] ball_x,
  output logic [W-1:0] ball_y,
  output logic [W-1:0] paddle_one_x,
  output logic [W-1:0] paddle_one_y,
  output logic [W-1:0] paddle_two_x,
  output logic [W-1:0] paddle_two_y,
  output logic [3:0]   score_one,
  output logic [3:0]   score_two,
  output logic         miss_left,
  output logic         miss_right,
  output logic         serving
);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  localparam logic [W-1:0] CX     = W'((H_RES - BALL_SIZE) / 2);
  localparam logic [W-1:0] CY     = W'((V_RES - BALL_SIZE) / 2);
  localparam logic [W-1:0] PAD_Y0 = W'((V_RES - PAD_H) / 2);
  localparam logic [W-1:0] L_FACE = W'(PAD_MARGIN + PAD_W);
  localparam logic [W-1:0] R_FACE = W'(H_RES - PAD_MARGIN - PAD_W - BALL_SIZE);
  localparam logic [W-1:0] Y_MAX  = W'(V_RES - BALL_SIZE);
  localparam logic [W-1:0] STEP   = W'(BALL_STEP);

  localparam logic [W:0] STEP_E   = (W+1)'(BALL_STEP);
  localparam logic [W:0] BS_E     = (W+1)'(BALL_SIZE);
  localparam logic [W:0] PH_E     = (W+1)'(PAD_H);
  localparam logic [W:0] R_FACE_E = (W+1)'(H_RES - PAD_MARGIN - PAD_W - BALL_SIZE);
  localparam logic [W:0] X_MAX_E  = (W+1)'(H_RES - BALL_SIZE);
  localparam logic [W:0] Y_MAX_E  = (W+1)'(V_RES - BALL_SIZE);

  localparam logic signed [W:0] TGT_OFS = (W+1)'(BALL_SIZE / 2 - PAD_H / 2);
  localparam logic signed [W:0] TGT_MAX = (W+1)'(V_RES - PAD_H);
  localparam logic signed [W:0] PSTEP   = (W+1)'(PAD_STEP);

  typedef enum logic {SERVE, PLAY} state_t;

  state_t           state;
  logic [CNT_W-1:0] serve_cnt;
  logic             dx_right;
  logic             dy_down;
  logic             vs_p0;
  logic             strobe;

  logic [W-1:0]     nx, ny;
  logic             ndx, ndy;
  logic             hit_l, hit_r, miss_l, miss_r;
  logic [W:0]       bx_e, by_e;
  logic signed [W:0] tgt;

  function automatic logic signed [W:0] clamp_target(input logic [W-1:0] y);
    logic signed [W:0] t;
    t = $signed({1'b0, y}) + TGT_OFS;
    if (t < 0) t = '0;
    else if (t > TGT_MAX) t = TGT_MAX;
    return t;
  endfunction

  function automatic logic [W-1:0] track(input logic [W-1:0] pad, input logic signed [W:0] target);
    logic signed [W:0] diff;
    diff = target - $signed({1'b0, pad});
    if (diff > PSTEP) return pad + W'(PAD_STEP);
    else if (diff < -PSTEP) return pad - W'(PAD_STEP);
    else return target[W-1:0];
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  assign paddle_one_x = W'(PAD_MARGIN);
  assign paddle_two_x = W'(H_RES - PAD_MARGIN - PAD_W);
  assign strobe       = en & vs_p0 & ~vs;
  assign bx_e         = {1'b0, ball_x};
  assign by_e         = {1'b0, ball_y};

  // Next-frame candidates, all from the pre-update state
  always_comb begin
    ny  = ball_y;
    ndy = dy_down;
    if (dy_down) begin
      if (by_e + STEP_E >= Y_MAX_E) begin
        ny  = Y_MAX;
        ndy = 1'b0;
      end else begin
        ny = ball_y + STEP;
      end
    end else begin
      if (ball_y <= STEP) begin
        ny  = '0;
        ndy = 1'b1;
      end else begin
        ny = ball_y - STEP;
      end
    end

    hit_l = ~dx_right && (ball_x >= L_FACE) && ((ball_x - STEP) <= L_FACE) &&
            (by_e + BS_E > {1'b0, paddle_one_y}) && (by_e < {1'b0, paddle_one_y} + PH_E);
    hit_r = dx_right && (ball_x <= R_FACE) && (bx_e + STEP_E >= R_FACE_E) &&
            (by_e + BS_E > {1'b0, paddle_two_y}) && (by_e < {1'b0, paddle_two_y} + PH_E);
    miss_l = ~dx_right && ~hit_l && (ball_x <= STEP);
    miss_r = dx_right && ~hit_r && (bx_e + STEP_E >= X_MAX_E);

    ndx = dx_right;
    if (hit_l) begin
      nx  = L_FACE;
      ndx = 1'b1;
    end else if (hit_r) begin
      nx  = R_FACE;
      ndx = 1'b0;
    end else if (dx_right) begin
      nx = ball_x + STEP;
    end else begin
      nx = ball_x - STEP;
    end

    tgt = clamp_target(ball_y);
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state        <= SERVE;
      serve_cnt    <= '0;
      serving      <= 1'b1;
      ball_x       <= CX;
      ball_y       <= CY;
      dx_right     <= 1'b1;
      dy_down      <= 1'b1;
      paddle_one_y <= PAD_Y0;
      paddle_two_y <= PAD_Y0;
      score_one    <= '0;
      score_two    <= '0;
      miss_left    <= 1'b0;
      miss_right   <= 1'b0;
      vs_p0        <= 1'b1;
    end else begin
      vs_p0      <= vs;
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
      if (strobe) begin
        case (state)
          SERVE: begin
            if (serve_cnt == CNT_LAST) begin
              serve_cnt <= '0;
              state     <= PLAY;
              serving   <= 1'b0;
            end else begin
              serve_cnt <= serve_cnt + 1'b1;
            end
          end
          PLAY: begin
            // Only the paddle the ball is heading toward chases it
            if (dx_right) paddle_two_y <= track(paddle_two_y, tgt);
            else          paddle_one_y <= track(paddle_one_y, tgt);
            if (miss_l || miss_r) begin
              ball_x    <= CX;
              ball_y    <= CY;
              state     <= SERVE;
              serving   <= 1'b1;
              serve_cnt <= '0;
              if (miss_l) begin
                miss_left <= 1'b1;
                score_two <= sat_inc(score_two);
                dx_right  <= 1'b1;
              end else begin
                miss_right <= 1'b1;
                score_one  <= sat_inc(score_one);
                dx_right   <= 1'b0;
              end
            end else begin
              ball_x   <= nx;
              ball_y   <= ny;
              dx_right <= ndx;
              dy_down  <= ndy;
            end
          end
          default: state <= SERVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_motion_gen.sv
// Randomized frame/enable stimulus on two configurations, compared every cycle
// against an integer game model; the second uses tiny static paddles so scores saturate.
module tb_pong_motion_gen;

  typedef struct {
    int hres, vres, bs, pw, ph, pm, bstep, pstep, sf;
  } cfg_t;

  typedef struct {
    int bx, by, p1, p2, s1, s2, ml, mr, play, cnt, right, down;
  } mdl_t;

  localparam cfg_t C1 = '{640, 480, 8, 8, 64, 16, 2, 1, 60};
  localparam cfg_t C2 = '{640, 480, 8, 8, 8, 16, 2, 0, 60};

  logic clk = 1'b0;
  logic rst, en, vs;

  logic [9:0] a_bx, a_by, a_p1x, a_p1y, a_p2x, a_p2y;
  logic [3:0] a_s1, a_s2;
  logic       a_ml, a_mr, a_sv;
  logic [9:0] b_bx, b_by, b_p1x, b_p1y, b_p2x, b_p2y;
  logic [3:0] b_s1, b_s2;
  logic       b_ml, b_mr, b_sv;

  int n_chk = 0;
  int n_err = 0;
  int sat_l = 0;
  int sat_r = 0;
  mdl_t m1, m2;
  logic prev_vs;

  always #10 clk = ~clk;

  pong_motion_gen dut1 (
    .clk50M(clk), .rst(rst), .en(en), .vs(vs),
    .ball_x(a_bx), .ball_y(a_by),
    .paddle_one_x(a_p1x), .paddle_one_y(a_p1y),
    .paddle_two_x(a_p2x), .paddle_two_y(a_p2y),
    .score_one(a_s1), .score_two(a_s2),
    .miss_left(a_ml), .miss_right(a_mr), .serving(a_sv)
  );

  pong_motion_gen #(.PAD_H(8), .PAD_STEP(0)) dut2 (
    .clk50M(clk), .rst(rst), .en(en), .vs(vs),
    .ball_x(b_bx), .ball_y(b_by),
    .paddle_one_x(b_p1x), .paddle_one_y(b_p1y),
    .paddle_two_x(b_p2x), .paddle_two_y(b_p2y),
    .score_one(b_s1), .score_two(b_s2),
    .miss_left(b_ml), .miss_right(b_mr), .serving(b_sv)
  );

  task automatic chk(input string tag, input logic [70:0] got, input logic [70:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic mdl_t m_reset(input cfg_t c);
    mdl_t m;
    m.bx = (c.hres - c.bs) / 2;  m.by = (c.vres - c.bs) / 2;
    m.p1 = (c.vres - c.ph) / 2;  m.p2 = m.p1;
    m.s1 = 0; m.s2 = 0; m.ml = 0; m.mr = 0;
    m.play = 0; m.cnt = 0; m.right = 1; m.down = 1;
    return m;
  endfunction

  function automatic int chase(input int pad, input int target, input int stp);
    int d;
    d = target - pad;
    if (d > stp) return pad + stp;
    if (d < -stp) return pad - stp;
    return target;
  endfunction

  // One frame of game rules
  function automatic mdl_t m_frame(input cfg_t c, input mdl_t m);
    mdl_t n;
    int target, lface, rface, hit, miss;
    n = m;
    if (m.play == 0) begin
      if (m.cnt == c.sf - 1) begin n.cnt = 0; n.play = 1; end
      else n.cnt = m.cnt + 1;
      return n;
    end
    target = m.by + c.bs / 2 - c.ph / 2;
    if (target < 0) target = 0;
    if (target > c.vres - c.ph) target = c.vres - c.ph;
    if (m.right != 0) n.p2 = chase(m.p2, target, c.pstep);
    else              n.p1 = chase(m.p1, target, c.pstep);

    lface = c.pm + c.pw;
    rface = c.hres - c.pm - c.pw - c.bs;
    if (m.right != 0) begin
      hit  = (m.bx <= rface && m.bx + c.bstep >= rface && m.by + c.bs > m.p2 && m.by < m.p2 + c.ph) ? 1 : 0;
      miss = (hit == 0 && m.bx + c.bstep >= c.hres - c.bs) ? 1 : 0;
    end else begin
      hit  = (m.bx >= lface && m.bx - c.bstep <= lface && m.by + c.bs > m.p1 && m.by < m.p1 + c.ph) ? 1 : 0;
      miss = (hit == 0 && m.bx <= c.bstep) ? 1 : 0;
    end

    if (miss != 0) begin
      n.bx = (c.hres - c.bs) / 2;  n.by = (c.vres - c.bs) / 2;
      n.play = 0; n.cnt = 0;
      if (m.right != 0) begin n.mr = 1; if (m.s1 < 15) n.s1 = m.s1 + 1; n.right = 0; end
      else              begin n.ml = 1; if (m.s2 < 15) n.s2 = m.s2 + 1; n.right = 1; end
      return n;
    end

    if (m.down != 0) begin
      if (m.by + c.bstep >= c.vres - c.bs) begin n.by = c.vres - c.bs; n.down = 0; end
      else n.by = m.by + c.bstep;
    end else begin
      if (m.by <= c.bstep) begin n.by = 0; n.down = 1; end
      else n.by = m.by - c.bstep;
    end

    if (hit != 0) begin
      n.bx    = (m.right != 0) ? rface : lface;
      n.right = (m.right != 0) ? 0 : 1;
    end else begin
      n.bx = (m.right != 0) ? m.bx + c.bstep : m.bx - c.bstep;
    end
    return n;
  endfunction

  function automatic logic [70:0] mpack(input cfg_t c, input mdl_t m);
    return {10'(m.bx), 10'(m.by), 10'(c.pm), 10'(m.p1), 10'(c.hres - c.pm - c.pw), 10'(m.p2),
            4'(m.s1), 4'(m.s2), 1'(m.ml), 1'(m.mr), (m.play == 0)};
  endfunction

  task automatic tick(input logic r, input logic e, input logic v);
    int s1_prev, s2_prev;
    logic stb;
    rst = r; en = e; vs = v;
    @(negedge clk);
    s1_prev = m2.s1;
    s2_prev = m2.s2;
    if (r) begin
      m1 = m_reset(C1);
      m2 = m_reset(C2);
      prev_vs = 1'b1;
    end else begin
      stb = e && prev_vs && !v;
      m1.ml = 0; m1.mr = 0; m2.ml = 0; m2.mr = 0;
      if (stb) begin
        m1 = m_frame(C1, m1);
        m2 = m_frame(C2, m2);
      end
      prev_vs = v;
    end
    chk("dut1_state", {a_bx, a_by, a_p1x, a_p1y, a_p2x, a_p2y, a_s1, a_s2, a_ml, a_mr, a_sv}, mpack(C1, m1));
    chk("dut2_state", {b_bx, b_by, b_p1x, b_p1y, b_p2x, b_p2y, b_s1, b_s2, b_ml, b_mr, b_sv}, mpack(C2, m2));
    if (m2.mr != 0 && s1_prev == 15) begin
      chk("sat_miss_right", {66'd0, b_mr, b_s1}, {66'd0, 1'b1, 4'd15});
      sat_r++;
    end
    if (m2.ml != 0 && s2_prev == 15) begin
      chk("sat_miss_left", {66'd0, b_ml, b_s2}, {66'd0, 1'b1, 4'd15});
      sat_l++;
    end
  endtask

  task automatic frame(input int lo, input int hi, input logic e);
    repeat (lo) tick(1'b0, e, 1'b0);
    repeat (hi) tick(1'b0, e, 1'b1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; vs = 1'b1;
    m1 = m_reset(C1);
    m2 = m_reset(C2);
    prev_vs = 1'b1;
    @(negedge clk);
    repeat (3) tick(1'b1, 1'b0, 1'b1);
    chk("reset_view", {40'd0, a_sv, a_bx, a_by, a_p1y, a_s1, a_s2, a_ml, a_mr},
        {40'd0, 1'b1, 10'd316, 10'd236, 10'd208, 4'd0, 4'd0, 1'b0, 1'b0});

    repeat (59) frame(1, 2, 1'b1);
    chk("serve_59", {70'd0, a_sv}, {70'd0, 1'b1});
    frame(1, 2, 1'b1);
    chk("serve_done", {30'd0, a_sv, a_bx, a_by, a_p1y, a_p2y},
        {30'd0, 1'b0, 10'd316, 10'd236, 10'd208, 10'd208});

    repeat (10) frame(1, 2, 1'b0);
    chk("en_freeze", {22'd0, a_sv, a_bx, a_by, a_p1y, a_p2y, a_s1, a_s2},
        {22'd0, 1'b0, 10'd316, 10'd236, 10'd208, 10'd208, 4'd0, 4'd0});

    repeat (20) frame($urandom_range(1, 3), $urandom_range(1, 3), 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_1", {a_bx, a_by, a_p1x, a_p1y, a_p2x, a_p2y, a_s1, a_s2, a_ml, a_mr, a_sv}, mpack(C1, m_reset(C1)));
    chk("async_rst_2", {b_bx, b_by, b_p1x, b_p1y, b_p2x, b_p2y, b_s1, b_s2, b_ml, b_mr, b_sv}, mpack(C2, m_reset(C2)));
    repeat (2) tick(1'b1, 1'b1, 1'b1);

    for (int f = 0; f < 12000; f++) begin
      frame($urandom_range(1, 2), $urandom_range(1, 2), ($urandom_range(0, 15) != 0));
      if (sat_l > 0 && sat_r > 0) break;
    end
    chk("sat_reached", {70'd0, (sat_l > 0 && sat_r > 0)}, {70'd0, 1'b1});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pong_motion_gen.md
PONG_MOTION_GEN -- requirements
Module: pong_motion_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- W, 10, coordinate width
- H_RES, 640, visible width
- V_RES, 480, visible height
- BALL_SIZE, 8, ball side in pixels
- PAD_W, 8, paddle width
- PAD_H, 64, paddle height
- PAD_MARGIN, 16, screen-edge-to-paddle gap
- BALL_STEP, 2, ball pixels per frame per axis
- PAD_STEP, 1, max paddle pixels per frame
- SERVE_FRAMES, 60, frames held at centre before play
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk50M, in, 1, sole clock; everything is rising-edge
- rst, in, 1, asynchronous active-high reset
- en, in, 1, run enable; 0 freezes all state
- vs, in, 1, active-low vertical sync from the graphics block (clk50M domain)
- ball_x / ball_y, out, W, ball top-left
- paddle_one_x / paddle_one_y, out, W, left paddle top-left
- paddle_two_x / paddle_two_y, out, W, right paddle top-left
- score_one / score_two, out, 4, per-player scores
- miss_left / miss_right, out, 1, one-cycle miss pulses
- serving, out, 1, high in SERVE state

Function
REQ-003 Frame strobe SHALL be asserted exactly one cycle after each 1->0 transition of vs, via one register stage; it SHALL be ignored when en=0.
REQ-004 All state SHALL update only on a strobe cycle, except miss pulses, which SHALL deassert on the next cycle.
REQ-005 paddle_one_x SHALL be constant PAD_MARGIN; paddle_two_x SHALL be constant H_RES-PAD_MARGIN-PAD_W.
REQ-006 FSM states SHALL be SERVE and PLAY. In SERVE, serve counter increments per strobe; the strobe with counter = SERVE_FRAMES-1 SHALL clear the counter and enter PLAY. In SERVE the ball SHALL hold at centre (CX=(H_RES-BALL_SIZE)/2, CY=(V_RES-BALL_SIZE)/2).
REQ-007 PLAY vertical motion: y += or -= BALL_STEP by dy. If moving down and ball_y+BALL_STEP >= V_RES-BALL_SIZE, set ball_y=V_RES-BALL_SIZE and flip dy. If moving up and ball_y <= BALL_STEP, set ball_y=0 and flip dy.
REQ-008 PLAY left paddle hit: all conditions true SHALL set ball_x=PAD_MARGIN+PAD_W and set dx=right:
- moving left
- ball_x >= PAD_MARGIN+PAD_W
- ball_x-BALL_STEP <= PAD_MARGIN+PAD_W
- ball_y+BALL_SIZE > paddle_one_y
- ball_y < paddle_one_y+PAD_H
The right paddle SHALL be the mirror case at face paddle_two_x-BALL_SIZE.
REQ-009 PLAY left miss: no hit while moving left with ball_x <= BALL_STEP SHALL:
- pulse miss_left
- increment score_two, saturating at 15
- recentre the ball, set dx=right, keep dy
- enter SERVE
Right miss SHALL be the mirror case (ball_x+BALL_STEP >= H_RES-BALL_SIZE; score_one; dx=left).
REQ-010 Otherwise ball_x SHALL move BALL_STEP along dx.
REQ-011 Priority SHALL be miss > paddle hit > free move. A wall bounce in the same strobe SHALL still apply unless a miss recentres the ball.
REQ-012 Paddle tracking SHALL apply in PLAY only, and only for the paddle the ball moves toward (dx at strobe start).
- target = clamp(ball_y+BALL_SIZE/2-PAD_H/2, 0, V_RES-PAD_H), computed from the pre-update ball_y with signed W+1-bit arithmetic
- paddle moves toward target by min(PAD_STEP, |diff|)
REQ-013 All coordinates SHALL stay within their legal range at all times; no wrap-around.

Reset
REQ-014 While rst is high, outputs SHALL be:
- state SERVE, serve counter 0, serving=1
- ball (CX,CY), dx=right, dy=down
- both paddle_y=(V_RES-PAD_H)/2
- scores 0, miss pulses 0, vs history register 1
REQ-015 Reset asserted mid-PLAY SHALL take effect immediately without waiting for a clock edge. The first strobe after release SHALL count as serve frame 0.

Verification
REQ-016 Reset, then 60 vs falling edges -> serving drops after the 60th strobe; ball (316,236); both paddle_y = 208.
REQ-017 en=0 across 10 vs edges -> every output unchanged; score and counter frozen.
REQ-018 PLAY, ball_y=470, dy=down, strobe -> ball_y=472 and dy=up; next strobe -> ball_y=470.
REQ-019 Ball (26,230), dx=left, paddle_one_y=208, strobe -> ball_x=24, dx=right, no miss_left.
REQ-020 Ball (2,10), dx=left, paddle_one_y=208 -> miss_left high exactly one cycle; score_two=1; ball (316,236); serving=1.
REQ-021 Force score_one=15, then a right miss -> score_one stays 15 and miss_right still pulses.
